// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with frame debounce and press-edge detection
//   clk        system clock
//   reset      asynchronous, active-high reset
//   key_row    row returns (active-high, asynchronous to clk)
//   key_col    one-hot column strobe
//   key        debounced key vector, bit = row*3 + col
//   key_press  one-cycle pulse when key gains new bits
//   key_code   index of lowest newly set bit, held between presses
//   key_any    registered OR of key
module keypad_scan #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key,
    output logic        key_press,
    output logic [3:0]  key_code,
    output logic        key_any
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [3:0]    row_s1, row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [11:0]   acc, frame_vec, cand, new_bits;
    logic [SW-1:0] stable;
    logic [3:0]    low_idx;
    logic          sample, frame_end, write_key;

    assign key_col = {col == 2'd2, col == 2'd1, col == 2'd0};

    // frame_vec is the accumulator with the current column's rows already merged in,
    // so at the column-2 sample edge it is the complete frame
    always_comb begin
        sample    = dwell == DW'(SCAN_DIV - 1);
        frame_end = sample && col == 2'd2;
        frame_vec = acc;
        for (int r = 0; r < 4; r++) frame_vec[r*3 + int'(col)] = row_s[r];
        write_key = frame_end && frame_vec == cand && int'(stable) + 1 == DEBOUNCE_FRAMES;
        new_bits  = frame_vec & ~key;
        low_idx   = '0;
        for (int i = 11; i >= 0; i--) if (new_bits[i]) low_idx = 4'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1    <= '0;
            row_s     <= '0;
            dwell     <= '0;
            col       <= '0;
            acc       <= '0;
            cand      <= '0;
            stable    <= '0;
            key       <= '0;
            key_press <= 1'b0;
            key_code  <= '0;
            key_any   <= 1'b0;
        end else begin
            row_s1    <= key_row;
            row_s     <= row_s1;
            key_any   <= |key;
            key_press <= 1'b0;
            dwell     <= sample ? '0 : dwell + 1'b1;
            if (sample) begin
                acc <= frame_vec;
                col <= col == 2'd2 ? 2'd0 : col + 2'd1;
            end
            if (frame_end) begin
                if (frame_vec != cand) begin
                    cand   <= frame_vec;
                    stable <= SW'(1);
                end else if (int'(stable) < DEBOUNCE_FRAMES) begin
                    stable <= stable + 1'b1;
                end
            end
            // stable saturates past DEBOUNCE_FRAMES-1, so a held vector is written once
            if (write_key) begin
                key <= frame_vec;
                if (|new_bits) begin
                    key_press <= 1'b1;
                    key_code  <= low_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a frame-level reference model
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DF = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key;
    logic        key_press;
    logic [3:0]  key_code;
    logic        key_any;
    logic [11:0] pressed = '0;

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;
    int p0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
        .key(key), .key_press(key_press), .key_code(key_code), .key_any(key_any)
    );

    always #5 clk = ~clk;

    always_comb for (int r = 0; r < 4; r++) key_row[r] = |(pressed[r*3 +: 3] & key_col);

    // Reference model: time-indexed column schedule, delayed keypad samples,
    // and a history of whole frames from which the debounce decision is read.
    int          cnt = 0;
    logic [11:0] hist[$];
    logic [11:0] frames[$];
    logic [11:0] m_acc = '0, m_key = '0;
    logic        m_press = 1'b0, m_any = 1'b0;
    logic [3:0]  m_code = '0;
    logic [2:0]  m_col = 3'b001;

    task automatic model_step();
        int          c = (cnt / SD) % 3;
        int          n;
        logic [11:0] h, nb;
        bit          same, fresh;
        hist.push_back(pressed);
        if (hist.size() > 3) void'(hist.pop_front());
        m_any   = |m_key;
        m_press = 1'b0;
        if (cnt % SD == SD - 1) begin
            h = hist[0];
            for (int r = 0; r < 4; r++) m_acc[r*3 + c] = h[r*3 + c];
            if (c == 2) begin
                frames.push_back(m_acc);
                if (frames.size() > DF + 1) void'(frames.pop_front());
                n = frames.size();
                same = n >= DF;
                if (same) for (int k = n - DF; k < n; k++) if (frames[k] != m_acc) same = 0;
                fresh = (n == DF) || (n > DF && frames[n-DF-1] != m_acc);
                if (same && fresh) begin
                    nb = m_acc & ~m_key;
                    if (nb != 0) begin
                        m_press = 1'b1;
                        for (int i = 11; i >= 0; i--) if (nb[i]) m_code = 4'(i);
                    end
                    m_key = m_acc;
                end
            end
        end
        cnt++;
        m_col = 3'b001 << ((cnt / SD) % 3);
    endtask

    initial begin : model
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                cnt = 0; hist.delete(); frames.delete();
                m_acc = '0; m_key = '0; m_press = 1'b0; m_code = '0; m_any = 1'b0; m_col = 3'b001;
            end else begin
                model_step();
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({key_col, key, key_press, key_code, key_any} !== {m_col, m_key, m_press, m_code, m_any}) begin
            errors++;
            $display("FAIL cycle t=%0t dut col=%b key=%h press=%b code=%0d any=%b model col=%b key=%h press=%b code=%0d any=%b",
                     $time, key_col, key, key_press, key_code, key_any, m_col, m_key, m_press, m_code, m_any);
        end
        if (key_press) pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_boundary();
        int i;
        for (i = 0; i < 20 && key_col != 3'b100; i++) @(negedge clk);
        for (i = 0; i < 20 && key_col != 3'b001; i++) @(negedge clk);
        chk("boundary", 32'(key_col), 32'b001);
    endtask

    task automatic wait_key(input string name, input logic [11:0] exp, input int lat);
        int i;
        for (i = 0; i < 60 && key !== exp; i++) @(negedge clk);
        chk(name, 32'(key), 32'(exp));
        vectors++;
        if (i < lat - 3 || i > lat + 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, i, lat);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(key_col), 32'b001);
        chk("rst_key", 32'(key), 32'h0);
        reset = 1'b0;
        // 1: idle scan
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i % 4 == 2) chk("idle_col", 32'(key_col), 32'(3'b001 << ((i / 4) % 3)));
        end
        chk("idle_key", 32'(key), 32'h0);
        chk("idle_pulses", 32'(pulses), 32'd0);
        // 2: single key 7
        wait_boundary();
        pressed = 12'h080;
        wait_key("t2_key", 12'h080, 36);
        chk("t2_press", 32'(key_press), 32'd1);
        chk("t2_code", 32'(key_code), 32'd7);
        chk("t2_any_lag", 32'(key_any), 32'd0);
        @(negedge clk);
        chk("t2_any", 32'(key_any), 32'd1);
        chk("t2_press_end", 32'(key_press), 32'd0);
        chk("t2_pulses", 32'(pulses), 32'd1);
        pressed = '0;
        repeat (60) @(negedge clk);
        chk("t2_rel_key", 32'(key), 32'h0);
        chk("t2_rel_code", 32'(key_code), 32'd7);
        chk("t2_rel_pulses", 32'(pulses), 32'd1);
        // 3: bounce key 1 then hold
        wait_boundary();
        p0 = pulses;
        for (int f = 0; f < 6; f++) begin
            pressed = (f % 2 == 0) ? 12'h002 : 12'h000;
            repeat (12) @(negedge clk);
            chk("t3_bounce_key", 32'(key), 32'h0);
        end
        pressed = 12'h002;
        wait_key("t3_key", 12'h002, 36);
        repeat (24) @(negedge clk);
        chk("t3_pulses", 32'(pulses - p0), 32'd1);
        chk("t3_code", 32'(key_code), 32'd1);
        // 4: key 3, then add 5, then release
        wait_boundary();
        pressed = 12'h008;
        wait_key("t4_key3", 12'h008, 36);
        chk("t4_code3", 32'(key_code), 32'd3);
        wait_boundary();
        p0 = pulses;
        pressed = 12'h028;
        wait_key("t4_key35", 12'h028, 36);
        chk("t4_press", 32'(key_press), 32'd1);
        chk("t4_code5", 32'(key_code), 32'd5);
        wait_boundary();
        p0 = pulses;
        pressed = '0;
        wait_key("t4_rel", 12'h000, 36);
        repeat (24) @(negedge clk);
        chk("t4_rel_pulses", 32'(pulses - p0), 32'd0);
        chk("t4_rel_code", 32'(key_code), 32'd5);
        // 5: keys 9 and 2 together
        wait_boundary();
        p0 = pulses;
        pressed = 12'h204;
        wait_key("t5_key", 12'h204, 36);
        chk("t5_code", 32'(key_code), 32'd2);
        repeat (24) @(negedge clk);
        chk("t5_pulses", 32'(pulses - p0), 32'd1);
        // 6: reset mid-frame with key held
        wait_boundary();
        pressed = 12'h080;
        wait_key("t6_key", 12'h080, 36);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_col", 32'(key_col), 32'b001);
        chk("t6_rst_key", 32'(key), 32'h0);
        chk("t6_rst_press", 32'(key_press), 32'd0);
        chk("t6_rst_code", 32'(key_code), 32'd0);
        chk("t6_rst_any", 32'(key_any), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        wait_key("t6_key_again", 12'h080, 36);
        chk("t6_code", 32'(key_code), 32'd7);
        repeat (24) @(negedge clk);
        chk("t6_pulses", 32'(pulses - p0), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
